// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from the upstream FIFO and serialises each as a UART frame (start, LSB-first data, optional parity, stop).
// Latency: fifo_rd_en is high the cycle after IDLE sees a non-empty FIFO; the start bit begins two cycles after the read strobe.
// Backpressure: a frame starts only while enable=1 and the FIFO is non-empty; a frame already started always runs to completion.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) between data and stop bits.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    // Reject parameter sets the framing logic cannot represent.
    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("fifo_uart_tx: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] shift_dn;
    logic             tx_nxt;
    logic             done_nxt;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_BIT = 1'(PARITY_ODD);
    logic             parity_bit;
    logic             parity_nxt;
`endif

    // Bit timer reaches its last count: the current serial bit ends at this edge.
    assign bit_end  = (cnt == CNT_LAST);
    assign shift_dn = shift_reg >> 1;

    // Read strobe and busy are pure decodes of the state register.
    assign fifo_rd_en = (state == REQ);
    assign busy       = (state != IDLE);

    // State, timers, shift register and the registered line/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift_reg  <= '0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shift_reg  <= shift_nxt;
            tx         <= tx_nxt;
            frame_done <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

    // Next-state decode; tx_nxt is the line level for the state being entered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift_reg;
        tx_nxt    = tx;
        done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity_bit;
`endif
        case (state)
            IDLE: begin
                tx_nxt  = 1'b1;
                cnt_nxt = '0;
                idx_nxt = '0;
                // fifo_empty is only looked at here, so a frame never pops twice.
                if (enable && !fifo_empty) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                // FIFO output is registered, so the popped word is valid now.
                shift_nxt = fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_nxt = (^fifo_data) ^ PARITY_BIT;
`endif
                cnt_nxt   = '0;
                idx_nxt   = '0;
                tx_nxt    = 1'b0;
                state_nxt = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    tx_nxt    = shift_reg[0];
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    shift_nxt = shift_dn;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = parity_bit;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx + IDX_ONE;
                        tx_nxt  = shift_dn[0];
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
`endif
            STOP: begin
                // idx is reused to count stop bits.
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (idx == STOP_LAST) begin
                        idx_nxt   = '0;
                        tx_nxt    = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + IDX_ONE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                // Unused encodings recover to an idle line.
                cnt_nxt   = '0;
                idx_nxt   = '0;
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO upstream, per-cycle trace log, frames rebuilt from bit-slot arithmetic.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int W     = 8;
    localparam int CPB   = 4;
    localparam int STOPB = 1;
    localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NSLOT = 1 + W + P + STOPB;
    localparam int F     = NSLOT * CPB;
    localparam int GAP   = STOPB * CPB + 3;
    localparam int LOGN  = 8192;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mem [0:255];
    int push_cnt = 0;
    int pop_cnt  = 0;

    logic tx_log   [LOGN];
    logic rd_log   [LOGN];
    logic busy_log [LOGN];
    logic done_log [LOGN];
    int   ecount = 0;

    logic [W-1:0] ws [8];

    fifo_uart_tx #(
        .WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .PARITY_ODD(PODD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    // FIFO model: registered output, valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[pop_cnt % 256];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    // Trace log sampled 3ns after each rising edge; index = edge number.
    always @(posedge clk) begin
        #3;
        ecount = ecount + 1;
        if (ecount < LOGN) begin
            tx_log[ecount]   = tx;
            rd_log[ecount]   = fifo_rd_en;
            busy_log[ecount] = busy;
            done_log[ecount] = frame_done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] w);
        mem[push_cnt % 256] = w;
        push_cnt = push_cnt + 1;
    endtask

    // Number of high samples of one logged signal over [a, b].
    function automatic int count_hi(input int sel, input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < LOGN) begin
                case (sel)
                    0: if (tx_log[i] === 1'b1) n++;
                    1: if (rd_log[i] === 1'b1) n++;
                    2: if (busy_log[i] === 1'b1) n++;
                    default: if (done_log[i] === 1'b1) n++;
                endcase
            end
        end
        return n;
    endfunction

    // Line level held over one bit slot, or 2'b10 if it moved inside the slot.
    function automatic logic [1:0] slot_val(input int start, input int slot);
        logic v;
        v = tx_log[start + slot * CPB];
        for (int j = 1; j < CPB; j++) begin
            if (tx_log[start + slot * CPB + j] !== v) return 2'b10;
        end
        return {1'b0, v};
    endfunction

    // Expected line level for a bit slot of the frame carrying word w.
    function automatic logic exp_bit(input logic [W-1:0] w, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= W) return w[slot-1];
        if (P == 1 && slot == W + 1) return (^w) ^ (PODD != 0);
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        push(8'hA5);
        cycles(5);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_checks++; if (pop_cnt !== 0) begin n_fail++; $display("FAIL reset_no_pop: got %0d pops want 0", pop_cnt); end
        enable = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_enable_low();
        int a, b;
        a = ecount + 1;
        cycles(20);
        b = ecount;
        n_checks++; if (count_hi(1, a, b) !== 0) begin n_fail++; $display("FAIL enable_low_rd: got %0d strobes want 0", count_hi(1, a, b)); end
        n_checks++; if (count_hi(2, a, b) !== 0) begin n_fail++; $display("FAIL enable_low_busy: got %0d busy cycles want 0", count_hi(2, a, b)); end
        n_checks++; if (count_hi(0, a, b) !== b - a + 1) begin n_fail++; $display("FAIL enable_low_tx_idle: got %0d high want %0d", count_hi(0, a, b), b - a + 1); end
        n_checks++; if (pop_cnt !== 0) begin n_fail++; $display("FAIL enable_low_pop: got %0d pops want 0", pop_cnt); end
    endtask

    task automatic test_single();
        int t0;
        logic [1:0] got;
        enable = 1'b1;
        t0 = ecount + 1;
        cycles(F + 10);
        n_checks++; if (rd_log[t0] !== 1'b1) begin n_fail++; $display("FAIL single_rd_pos: got %b want 1", rd_log[t0]); end
        n_checks++; if (count_hi(1, t0 - 1, ecount) !== 1) begin n_fail++; $display("FAIL single_rd_count: got %0d want 1", count_hi(1, t0 - 1, ecount)); end
        n_checks++; if ({tx_log[t0], tx_log[t0+1]} !== 2'b11) begin n_fail++; $display("FAIL single_pre_start: got %b%b want 11", tx_log[t0], tx_log[t0+1]); end
        for (int s = 0; s < NSLOT; s++) begin
            got = slot_val(t0 + 2, s);
            n_checks++; if (got !== {1'b0, exp_bit(8'hA5, s)}) begin n_fail++; $display("FAIL single_slot%0d: got %b want %b", s, got, exp_bit(8'hA5, s)); end
        end
        n_checks++; if (count_hi(2, t0 - 1, ecount) !== F + 2) begin n_fail++; $display("FAIL single_busy_len: got %0d want %0d", count_hi(2, t0 - 1, ecount), F + 2); end
        n_checks++; if (done_log[t0 + 2 + F] !== 1'b1) begin n_fail++; $display("FAIL single_done_pos: got %b want 1", done_log[t0 + 2 + F]); end
        n_checks++; if (count_hi(3, t0 - 1, ecount) !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", count_hi(3, t0 - 1, ecount)); end
    endtask

    task automatic test_back_to_back(input logic [W-1:0] wl [8], input int n, input string tag);
        int t0, base, g0;
        logic [1:0] got;
        for (int i = 0; i < n; i++) push(wl[i]);
        t0 = ecount + 1;
        cycles(n * (F + 3) + 10);
        n_checks++; if (count_hi(1, t0 - 1, ecount) !== n) begin n_fail++; $display("FAIL %s_rd_count: got %0d want %0d", tag, count_hi(1, t0 - 1, ecount), n); end
        for (int f = 0; f < n; f++) begin
            base = t0 + f * (F + 3);
            n_checks++; if (rd_log[base] !== 1'b1) begin n_fail++; $display("FAIL %s_rd_pos%0d: got %b want 1", tag, f, rd_log[base]); end
            for (int s = 0; s < NSLOT; s++) begin
                got = slot_val(base + 2, s);
                n_checks++; if (got !== {1'b0, exp_bit(wl[f], s)}) begin n_fail++; $display("FAIL %s_f%0d_slot%0d: got %b want %b", tag, f, s, got, exp_bit(wl[f], s)); end
            end
            if (f < n - 1) begin
                g0 = base + 2 + F - STOPB * CPB;
                n_checks++; if (count_hi(0, g0, g0 + GAP - 1) !== GAP) begin n_fail++; $display("FAIL %s_gap%0d: got %0d high want %0d", tag, f, count_hi(0, g0, g0 + GAP - 1), GAP); end
            end
        end
        n_checks++; if (busy_log[ecount] !== 1'b0) begin n_fail++; $display("FAIL %s_idle_end: got busy %b want 0", tag, busy_log[ecount]); end
        n_checks++; if (pop_cnt !== push_cnt) begin n_fail++; $display("FAIL %s_drained: got %0d left want 0", tag, push_cnt - pop_cnt); end
    endtask

    task automatic test_enable_drop();
        int t0, t1;
        logic [W-1:0] wa, wb;
        logic [1:0] got;
        wa = W'($urandom);
        wb = W'($urandom);
        enable = 1'b1;
        push(wa);
        push(wb);
        t0 = ecount + 1;
        cycles(3);
        n_checks++; if ({busy, tx} !== 2'b10) begin n_fail++; $display("FAIL drop_in_start: got busy,tx=%b%b want 10", busy, tx); end
        enable = 1'b0;
        cycles(F + 3 * CPB + 20);
        n_checks++; if (count_hi(1, t0 - 1, ecount) !== 1) begin n_fail++; $display("FAIL drop_rd_count: got %0d want 1", count_hi(1, t0 - 1, ecount)); end
        for (int s = 0; s < NSLOT; s++) begin
            got = slot_val(t0 + 2, s);
            n_checks++; if (got !== {1'b0, exp_bit(wa, s)}) begin n_fail++; $display("FAIL drop_slot%0d: got %b want %b", s, got, exp_bit(wa, s)); end
        end
        n_checks++; if (count_hi(2, t0 - 1, ecount) !== F + 2) begin n_fail++; $display("FAIL drop_busy_len: got %0d want %0d", count_hi(2, t0 - 1, ecount), F + 2); end
        n_checks++; if (count_hi(0, t0 + 2 + F, ecount) !== ecount - (t0 + 2 + F) + 1) begin n_fail++; $display("FAIL drop_line_idle: got %0d high want %0d", count_hi(0, t0 + 2 + F, ecount), ecount - (t0 + 2 + F) + 1); end
        n_checks++; if (push_cnt - pop_cnt !== 1) begin n_fail++; $display("FAIL drop_pending: got %0d words want 1", push_cnt - pop_cnt); end
        enable = 1'b1;
        t1 = ecount + 1;
        cycles(F + 10);
        n_checks++; if (rd_log[t1] !== 1'b1) begin n_fail++; $display("FAIL drain_rd_pos: got %b want 1", rd_log[t1]); end
        for (int s = 0; s < NSLOT; s++) begin
            got = slot_val(t1 + 2, s);
            n_checks++; if (got !== {1'b0, exp_bit(wb, s)}) begin n_fail++; $display("FAIL drain_slot%0d: got %b want %b", s, got, exp_bit(wb, s)); end
        end
    endtask

    task automatic test_reset_mid();
        int a, b;
        logic [W-1:0] w;
        w = W'($urandom) & 8'hF7;
        enable = 1'b1;
        push(w);
        cycles(20);
        // Data bit 3 occupies samples t0+18..t0+21; this is t0+19.
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pre: got tx %b want 0", tx); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_mid_tx: got %b want 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        cycles(3);
        reset = 1'b0;
        n_checks++; if (pop_cnt !== push_cnt) begin n_fail++; $display("FAIL reset_mid_fifo: got %0d left want 0", push_cnt - pop_cnt); end
        a = ecount + 1;
        cycles(60);
        b = ecount;
        n_checks++; if (count_hi(0, a, b) !== b - a + 1) begin n_fail++; $display("FAIL reset_mid_quiet_tx: got %0d high want %0d", count_hi(0, a, b), b - a + 1); end
        n_checks++; if (count_hi(1, a, b) !== 0) begin n_fail++; $display("FAIL reset_mid_rd: got %0d strobes want 0", count_hi(1, a, b)); end
        n_checks++; if (count_hi(2, a, b) + count_hi(3, a, b) !== 0) begin n_fail++; $display("FAIL reset_mid_busy_done: got %0d want 0", count_hi(2, a, b) + count_hi(3, a, b)); end
    endtask

    initial begin
        test_reset();
        test_enable_low();
        test_single();
        ws = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        test_back_to_back(ws, 3, "b2b");
        ws[0] = 8'h07;
        for (int i = 1; i < 8; i++) ws[i] = W'($urandom);
        test_back_to_back(ws, 8, "rand");
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
